// File: rtl/gray_fifo_ctrl_pkg.sv
// Shared helpers for the Gray-pointer FIFO controller.
//   ptr_w : pointer width for a given RAM address width (one extra wrap bit
//           distinguishes full from empty).
package gray_fifo_ctrl_pkg;

    function automatic int unsigned ptr_w(input int unsigned addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/gray_fifo_ctrl_ptr.sv
// gray_ptr: enable-gated Gray-code counter with a binary shadow.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, counter -> 0
//   clr   : synchronous clear, counter -> 0 (wins over inc)
//   inc   : advance one Gray step
//   gray  : registered Gray count (gw bits)
//   bin   : binary equivalent of gray (combinational decode)
module gray_ptr #(
    parameter int unsigned gw = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [gw-1:0] gray,
    output logic [gw-1:0] bin
);

    logic [gw-1:0] bin_cur;
    logic [gw-1:0] bin_inc;
    logic [gw-1:0] gray_nxt;

    // Only the Gray value is stored; binary bit i is the XOR of Gray bits
    // i and above, so increment goes Gray -> binary -> +1 -> Gray.
    always_comb begin
        bin_cur = '0;
        for (int unsigned i = 0; i < gw; i++) begin
            bin_cur[i] = ^(gray >> i);
        end
        bin_inc  = bin_cur + gw'(1);
        gray_nxt = bin_inc ^ (bin_inc >> 1);
    end

    assign bin = bin_cur;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray <= '0;
        end else if (clr) begin
            gray <= '0;
        end else if (inc) begin
            gray <= gray_nxt;
        end
    end

endmodule

// File: rtl/gray_fifo_ctrl.sv
// gray_fifo_ctrl: single-clock FIFO pointer controller for an external
// dual-port async-read RAM, with Gray-coded pointers exported for CDC.
//   clk, rst_n          : clock, asynchronous active-low reset
//   clr                 : synchronous flush (pointers, level, peak -> 0)
//   in_valid / in_ready : write handshake, in_ready = !full
//   out_valid/out_ready : read handshake, out_valid = !empty
//   mem_we, mem_waddr   : RAM write strobe and address
//   mem_raddr           : RAM read address (head of FIFO)
//   wr_gray, rd_gray    : registered Gray pointers (aw+1 bits)
//   level, peak         : occupancy and its high-water mark
module gray_fifo_ctrl
    import gray_fifo_ctrl_pkg::*;
#(
    parameter int unsigned aw = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          mem_we,
    output logic [aw-1:0] mem_waddr,
    output logic [aw-1:0] mem_raddr,
    output logic [aw:0]   wr_gray,
    output logic [aw:0]   rd_gray,
    output logic [aw:0]   level,
    output logic [aw:0]   peak
);

    localparam int unsigned pw = ptr_w(aw);

    logic [aw:0] wr_bin;
    logic [aw:0] rd_bin;
    logic [aw:0] wr_bin_nxt;
    logic [aw:0] rd_bin_nxt;
    logic        full;
    logic        empty;
    logic        wr;
    logic        rd;

    gray_ptr #(.gw(pw)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (wr),
        .gray  (wr_gray),
        .bin   (wr_bin)
    );

    gray_ptr #(.gw(pw)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (rd),
        .gray  (rd_gray),
        .bin   (rd_bin)
    );

    // Full: write pointer one lap ahead, which in Gray means the top two
    // bits inverted and the rest equal.
    generate
        if (aw == 1) begin : g_full_narrow
            always_comb full = (wr_gray == ~rd_gray);
        end else begin : g_full_wide
            always_comb full = (wr_gray == {~rd_gray[aw:aw-1], rd_gray[aw-2:0]});
        end
    endgenerate

    always_comb begin
        empty      = (wr_gray == rd_gray);
        in_ready   = ~full;
        out_valid  = ~empty;
        // clr suppresses both handshakes in its cycle
        wr         = in_valid & ~full & ~clr;
        rd         = out_ready & ~empty & ~clr;
        mem_we     = wr;
        mem_waddr  = wr_bin[aw-1:0];
        mem_raddr  = rd_bin[aw-1:0];
        wr_bin_nxt = wr_bin + {{aw{1'b0}}, wr};
        rd_bin_nxt = rd_bin + {{aw{1'b0}}, rd};
    end

    // level tracks the pointers in the same edge; peak follows level one
    // cycle later since it compares against the registered level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            peak  <= '0;
        end else if (clr) begin
            level <= '0;
            peak  <= '0;
        end else begin
            level <= wr_bin_nxt - rd_bin_nxt;
            if (level > peak) begin
                peak <= level;
            end
        end
    end

endmodule

// File: tb/tb_gray_fifo_ctrl.sv
module tb_gray_fifo_ctrl;

    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          in_valid;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [AW-1:0] mem_raddr;
    logic [AW:0]   wr_gray;
    logic [AW:0]   rd_gray;
    logic [AW:0]   level;
    logic [AW:0]   peak;

    always #5 clk = ~clk;

    gray_fifo_ctrl #(.aw(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_raddr (mem_raddr),
        .wr_gray   (wr_gray),
        .rd_gray   (rd_gray),
        .level     (level),
        .peak      (peak)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: a queue of stored words plus total accept counts.
    int          q[$];
    int unsigned wcnt;
    int unsigned rcnt;
    int          peak_m;
    logic [7:0]  ram [DEPTH];
    logic [7:0]  din;
    logic [AW:0] prev_wg;
    logic [AW:0] prev_rg;
    logic        saw_wrap;

    function automatic logic [AW:0] gray_of(input int unsigned p);
        logic [AW:0] b;
        b = (AW+1)'(p % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wcnt   = 0;
        rcnt   = 0;
        peak_m = 0;
    endtask

    task automatic check_state();
        chk("in_ready",  32'(in_ready),  32'(q.size() < int'(DEPTH)));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("level",     32'(level),     32'(q.size()));
        chk("peak",      32'(peak),      32'(peak_m));
        chk("wr_gray",   32'(wr_gray),   32'(gray_of(wcnt)));
        chk("rd_gray",   32'(rd_gray),   32'(gray_of(rcnt)));
        chk("mem_waddr", 32'(mem_waddr), wcnt % DEPTH);
        chk("mem_raddr", 32'(mem_raddr), rcnt % DEPTH);
        if (q.size() > 0) begin
            chk("head_data", 32'(ram[mem_raddr]), 32'(q[0]));
        end
    endtask

    // Called one time unit after a rising edge; returns likewise.
    task automatic cycle(input logic iv, input logic orr, input logic cl);
        logic acc_w;
        logic acc_r;
        in_valid  = iv;
        out_ready = orr;
        clr       = cl;
        din       = 8'($urandom);
        @(negedge clk);
        check_state();
        acc_w = iv && (q.size() < int'(DEPTH)) && !cl;
        acc_r = orr && (q.size() > 0) && !cl;
        chk("mem_we", 32'(mem_we), 32'(acc_w));
        if (mem_we === 1'b1) ram[mem_waddr] = din;
        prev_wg = wr_gray;
        prev_rg = rd_gray;
        @(posedge clk);
        if (cl) begin
            model_reset();
        end else begin
            if (q.size() > peak_m) peak_m = q.size();
            if (acc_r) begin
                void'(q.pop_front());
                rcnt++;
            end
            if (acc_w) begin
                q.push_back(int'(din));
                wcnt++;
            end
        end
        #1;
        if (!cl) begin
            chk("wr_gray_onebit", 32'($countones(wr_gray ^ prev_wg) <= 1), 32'd1);
            chk("rd_gray_onebit", 32'($countones(rd_gray ^ prev_rg) <= 1), 32'd1);
            if (prev_rg == 3'b100 && rd_gray == 3'b000) saw_wrap = 1'b1;
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic reset_pulse();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_state();
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [AW:0] seq [5];
        seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110};
        saw_wrap  = 1'b0;
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state();
        rst_n = 1'b1;

        // 1: four writes into an idle reader
        for (int i = 0; i < 4; i++) begin
            chk("t1_wr_gray_seq", 32'(wr_gray), 32'(seq[i]));
            cycle(1'b1, 1'b0, 1'b0);
        end
        chk("t1_wr_gray_seq", 32'(wr_gray), 32'(seq[4]));
        chk("t1_in_ready", 32'(in_ready), 32'd0);
        chk("t1_level", 32'(level), 32'd4);
        cycle(1'b0, 1'b0, 1'b0);
        chk("t1_peak", 32'(peak), 32'd4);

        // 2: write+read while full -> read only
        cycle(1'b1, 1'b1, 1'b0);
        chk("t2_level", 32'(level), 32'd3);
        chk("t2_rd_gray", 32'(rd_gray), 32'd1);
        chk("t2_in_ready", 32'(in_ready), 32'd1);

        // 3: drain, then write+read while empty -> write only
        repeat (3) cycle(1'b0, 1'b1, 1'b0);
        chk("t3_empty", 32'(out_valid), 32'd0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("t3_out_valid", 32'(out_valid), 32'd1);
        chk("t3_level", 32'(level), 32'd1);

        // 4: steady stream at level 2
        cycle(1'b0, 1'b1, 1'b0);
        repeat (2) cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 1'b0);
            chk("t4_level", 32'(level), 32'd2);
        end
        chk("t4_rd_wrap_seen", 32'(saw_wrap), 32'd1);

        // 5: clr at level 3 with a write offered
        cycle(1'b1, 1'b0, 1'b0);
        chk("t5_level_pre", 32'(level), 32'd3);
        cycle(1'b1, 1'b0, 1'b1);
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_peak", 32'(peak), 32'd0);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);

        // 6: random traffic with occasional clr and a mid-burst reset
        for (int i = 0; i < 300; i++) begin
            if (i == 150) begin
                in_valid  = 1'b1;
                out_ready = 1'b1;
                reset_pulse();
            end
            cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 50) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
